// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: NUM_CH independent pulse channels, each a small
// IDLE/HIGH/LOW machine. In periodic mode a channel runs while enable is high.
// In one-shot mode a trigger fires a single pulse followed by a holdoff.
// Period and width are latched and clamped at every start or restart point,
// so input changes while busy only take effect at the next latch point.
module pulse_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       trigger,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*CNT_W-1:0] period,
    input  logic [NUM_CH*CNT_W-1:0] width,
    output logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       missed
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg,   cnt_next;
            logic [CNT_W-1:0] per_reg,   per_next;
            logic [CNT_W-1:0] wid_reg,   wid_next;
            logic             mode_reg,  mode_next;
            logic             pulse_reg;
            logic [CNT_W-1:0] per_in, wid_in;
            logic [CNT_W-1:0] per_clamp, wid_clamp;
            logic             start_req;
            logic             last_low;
            logic             busy_o, missed_o;

            assign per_in = period[gi*CNT_W +: CNT_W];
            assign wid_in = width[gi*CNT_W +: CNT_W];

            // Start request as judged from the live inputs at a latch point
            always_comb begin
                start_req = mode[gi] ? trigger[gi] : enable[gi];
            end

            // Clamp: P >= 2, 1 <= W <= P-1, so both phases last at least one cycle
            always_comb begin
                per_clamp = (per_in < TWO) ? TWO : per_in;
                wid_clamp = (wid_in == '0) ? ONE : wid_in;
                if (wid_clamp >= per_clamp) begin
                    wid_clamp = per_clamp - ONE;
                end
            end

            // Final LOW cycle: the edge ending it is also a latch point
            assign last_low = (state_reg == ST_LOW) && (cnt_reg == '0);

            // State register with latched config and registered pulse output
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    per_reg   <= '0;
                    wid_reg   <= '0;
                    mode_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    per_reg   <= per_next;
                    wid_reg   <= wid_next;
                    mode_reg  <= mode_next;
                    pulse_reg <= (state_next == ST_HIGH);
                end
            end

            // Next-state logic; counters load phase length minus one and count to zero
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                per_next   = per_reg;
                wid_next   = wid_reg;
                mode_next  = mode_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (start_req) begin
                            state_next = ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_reg == '0) begin
                            state_next = ST_LOW;
                            cnt_next   = per_reg - wid_reg - ONE;
                        end else begin
                            cnt_next = cnt_reg - ONE;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_reg == '0) begin
                            state_next = start_req ? ST_HIGH : ST_IDLE;
                        end else begin
                            cnt_next = cnt_reg - ONE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
                // Any entry into HIGH from IDLE or the last LOW cycle re-latches config
                if ((state_reg == ST_IDLE || last_low) && start_req) begin
                    per_next  = per_clamp;
                    wid_next  = wid_clamp;
                    mode_next = mode[gi];
                    cnt_next  = wid_clamp - ONE;
                end
            end

            // Outputs: busy from state, missed flags a one-shot trigger that cannot be taken
            always_comb begin
                busy_o   = (state_reg != ST_IDLE);
                missed_o = rst_n && trigger[gi] && busy_o && mode_reg
                           && !(last_low && start_req);
            end

            assign pulse[gi]  = pulse_reg;
            assign busy[gi]   = busy_o;
            assign missed[gi] = missed_o;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Testbench for pulse_gen_multi. The reference model describes each channel
// run as a start cycle plus clamped P and W: pulse is high for cycles
// [start, start+W), busy for [start, start+P). A new start is possible once
// the run has ended.
module tb_pulse_gen_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       enable, trigger, mode;
    logic [NUM_CH*CNT_W-1:0] period, width;
    logic [NUM_CH-1:0]       pulse, busy, missed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger), .mode(mode),
        .period(period), .width(width), .pulse(pulse), .busy(busy), .missed(missed)
    );

    // Reference model state
    int cyc = 0;
    bit act[NUM_CH];
    int st[NUM_CH];
    int pm[NUM_CH];
    int wm[NUM_CH];
    bit mm[NUM_CH];
    logic [NUM_CH-1:0] exp_pulse, exp_busy, exp_missed;

    function automatic bit want_start(input int ch);
        return mode[ch] ? trigger[ch] : enable[ch];
    endfunction

    // Expected outputs for the current cycle under the current inputs
    function automatic void calc_expect();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit b;
            b = act[ch] && (cyc < st[ch] + pm[ch]);
            exp_busy[ch]   = b;
            exp_pulse[ch]  = act[ch] && (cyc < st[ch] + wm[ch]);
            exp_missed[ch] = (rst_n === 1'b1) && trigger[ch] && b && mm[ch]
                             && !((cyc == st[ch] + pm[ch] - 1) && want_start(ch));
        end
    endfunction

    // One clock edge: advance the model with the inputs the DUT samples
    task automatic tick();
        int n;
        @(posedge clk);
        n = cyc + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rst_n !== 1'b1) begin
                act[ch] = 1'b0;
            end else if (!(act[ch] && n < st[ch] + pm[ch])) begin
                if (want_start(ch)) begin
                    int p, w;
                    p = int'(period[ch*CNT_W +: CNT_W]);
                    w = int'(width[ch*CNT_W +: CNT_W]);
                    if (p < 2) p = 2;
                    if (w < 1) w = 1;
                    if (w >= p) w = p - 1;
                    act[ch] = 1'b1;
                    st[ch]  = n;
                    pm[ch]  = p;
                    wm[ch]  = w;
                    mm[ch]  = mode[ch];
                end else begin
                    act[ch] = 1'b0;
                end
            end
        end
        cyc = n;
        #1;
    endtask

    task automatic set_ch(input int ch, input int p, input int w);
        period[ch*CNT_W +: CNT_W] = CNT_W'(p);
        width[ch*CNT_W +: CNT_W]  = CNT_W'(w);
    endtask

    // Return every channel to IDLE with a one-cycle reset
    task automatic quiesce();
        enable = '0; trigger = '0; mode = '0; period = '0; width = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 4'b1111; trigger = 4'b1111; mode = 4'b0101;
        set_ch(0, 3, 1); set_ch(1, 4, 2); set_ch(2, 5, 2); set_ch(3, 6, 3);
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({pulse, busy, missed} !== 12'b0) begin
            bad++;
            $display("FAIL reset_state pulse=%b busy=%b missed=%b want all 0", pulse, busy, missed);
        end
        tick();
        quiesce();
        $display("test_reset: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_periodic_long();
        int rises = 0, last_rise = 0, run = 0;
        logic prev = 1'b0;
        quiesce();
        mode[0] = 1'b0; set_ch(0, 1000, 1); enable[0] = 1'b1;
        for (int i = 0; i < 3005; i++) begin
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL periodic cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (pulse[0] && !prev) begin
                if (rises > 0) begin
                    total++;
                    if (i - last_rise != 1000) begin
                        bad++;
                        $display("FAIL periodic_interval got=%0d want=1000", i - last_rise);
                    end
                end
                rises++;
                last_rise = i;
            end
            if (pulse[0]) run++;
            if (!pulse[0] && prev) begin
                total++;
                if (run != 1) begin
                    bad++;
                    $display("FAIL periodic_width got=%0d want=1", run);
                end
                run = 0;
            end
            prev = pulse[0];
            tick();
        end
        total++;
        if (rises != 4) begin
            bad++;
            $display("FAIL periodic_rises got=%0d want=4", rises);
        end
        $display("test_periodic_long: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_enable_drop();
        int highs = 0, busies = 0, rises = 0;
        logic prev = 1'b0;
        quiesce();
        mode[1] = 1'b0; set_ch(1, 10, 4); enable[1] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) enable[1] = 1'b0;
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL enable_drop cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (pulse[1]) highs++;
            if (busy[1]) busies++;
            if (pulse[1] && !prev) rises++;
            prev = pulse[1];
            tick();
        end
        total++;
        if (highs != 4 || busies != 10 || rises != 1) begin
            bad++;
            $display("FAIL enable_drop_shape highs=%0d busy=%0d rises=%0d want 4/10/1", highs, busies, rises);
        end
        $display("test_enable_drop: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_oneshot_missed();
        int highs = 0, busies = 0, misses = 0, miss_at = -1;
        quiesce();
        mode[2] = 1'b1; set_ch(2, 20, 3);
        for (int i = 0; i < 30; i++) begin
            trigger[2] = (i == 0 || i == 5);
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL oneshot cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (pulse[2]) highs++;
            if (busy[2]) busies++;
            if (missed[2]) begin misses++; miss_at = i; end
            tick();
        end
        total++;
        if (highs != 3 || busies != 20 || misses != 1 || miss_at != 5) begin
            bad++;
            $display("FAIL oneshot_shape highs=%0d busy=%0d misses=%0d at=%0d want 3/20/1/5",
                     highs, busies, misses, miss_at);
        end
        $display("test_oneshot_missed: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_clamp();
        int run_hi = 0, run_lo = 0;
        logic prev0 = 1'b0, prev1 = 1'b0;
        bit started0 = 1'b0, started1 = 1'b0;
        quiesce();
        set_ch(0, 0, 0); set_ch(1, 5, 9); enable[1:0] = 2'b11;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL clamp cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (started0) begin
                total++;
                if (pulse[0] === prev0) begin
                    bad++;
                    $display("FAIL clamp_alternate i=%0d got=%b want=%b", i, pulse[0], ~prev0);
                end
            end
            if (pulse[0]) started0 = 1'b1;
            prev0 = pulse[0];
            if (pulse[1]) begin
                if (!prev1 && started1) begin
                    total++;
                    if (run_lo != 1) begin
                        bad++;
                        $display("FAIL clamp_low got=%0d want=1", run_lo);
                    end
                end
                started1 = 1'b1; run_hi++; run_lo = 0;
            end else if (started1) begin
                if (prev1) begin
                    total++;
                    if (run_hi != 4) begin
                        bad++;
                        $display("FAIL clamp_high got=%0d want=4", run_hi);
                    end
                end
                run_lo++; run_hi = 0;
            end
            prev1 = pulse[1];
            tick();
        end
        $display("test_clamp: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_reset_mid();
        quiesce();
        set_ch(0, 5, 2); set_ch(1, 6, 3); set_ch(2, 7, 1); set_ch(3, 9, 4);
        enable = 4'b1111;
        for (int i = 0; i < 45; i++) begin
            if (i == 23) rst_n = 1'b0;
            if (i == 24) rst_n = 1'b1;
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (i == 24) begin
                total++;
                if ({pulse, busy} !== 8'b0) begin
                    bad++;
                    $display("FAIL reset_abort pulse=%b busy=%b want 0", pulse, busy);
                end
            end
            if (i == 25) begin
                total++;
                if (pulse !== 4'b1111) begin
                    bad++;
                    $display("FAIL reset_restart pulse=%b want=1111", pulse);
                end
            end
            tick();
        end
        $display("test_reset_mid: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_independence();
        int last0 = -1, last3 = -1;
        logic [NUM_CH-1:0] prev = '0;
        quiesce();
        set_ch(0, 7, int'($urandom_range(6, 1)));
        set_ch(3, 11, int'($urandom_range(10, 1)));
        enable = 4'b1001;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL independence cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (pulse[0] && !prev[0]) begin
                if (last0 >= 0) begin
                    total++;
                    if (i - last0 != 7) begin
                        bad++;
                        $display("FAIL indep_ch0_interval got=%0d want=7", i - last0);
                    end
                end
                last0 = i;
            end
            if (pulse[3] && !prev[3]) begin
                if (last3 >= 0) begin
                    total++;
                    if (i - last3 != 11) begin
                        bad++;
                        $display("FAIL indep_ch3_interval got=%0d want=11", i - last3);
                    end
                end
                last3 = i;
            end
            prev = pulse;
            tick();
        end
        $display("test_independence: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_back_to_back();
        int last = -1;
        logic prev = 1'b0;
        quiesce();
        mode[1] = 1'b1; set_ch(1, 6, 2); trigger[1] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            if (pulse[1] && !prev) begin
                if (last >= 0) begin
                    total++;
                    if (i - last != 6) begin
                        bad++;
                        $display("FAIL b2b_interval got=%0d want=6", i - last);
                    end
                end
                last = i;
            end
            prev = pulse[1];
            tick();
        end
        $display("test_back_to_back: done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_random();
        quiesce();
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(15, 0) == 0) enable[ch] = ~enable[ch];
                if ($urandom_range(31, 0) == 0) mode[ch] = ~mode[ch];
                trigger[ch] = ($urandom_range(4, 0) == 0);
                if ($urandom_range(7, 0) == 0)
                    set_ch(ch, int'($urandom_range(12, 0)), int'($urandom_range(12, 0)));
            end
            rst_n = ($urandom_range(199, 0) != 0);
            @(negedge clk);
            calc_expect();
            total++;
            if ({pulse, busy, missed} !== {exp_pulse, exp_busy, exp_missed}) begin
                bad++;
                $display("FAIL random cyc=%0d pulse=%b/%b busy=%b/%b missed=%b/%b",
                         cyc, pulse, exp_pulse, busy, exp_busy, missed, exp_missed);
            end
            tick();
        end
        rst_n = 1'b1;
        $display("test_random: done total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = '0; trigger = '0; mode = '0; period = '0; width = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            act[ch] = 1'b0; st[ch] = 0; pm[ch] = 0; wm[ch] = 0; mm[ch] = 1'b0;
        end
        test_reset();
        test_periodic_long();
        test_enable_drop();
        test_oneshot_missed();
        test_clamp();
        test_reset_mid();
        test_independence();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
